// File: rtl/button_event_decoder_if.sv
// button_event_decoder_if: debounced button level in, event pulses out
interface button_event_decoder_if;
  logic i_Debounced;
  logic o_Press;
  logic o_Release;
  logic o_Short_Click;
  logic o_Double_Click;
  logic o_Long_Press;
  modport master (
    output i_Debounced,
    input  o_Press, o_Release, o_Short_Click, o_Double_Click, o_Long_Press
  );
  modport slave (
    input  i_Debounced,
    output o_Press, o_Release, o_Short_Click, o_Double_Click, o_Long_Press
  );
endinterface

// File: rtl/button_event_decoder.sv
// button_event_decoder: debounced level to press/release/click/double/long pulses; BUTTON_EVENT_DOUBLE_CLICK_EN enables the double-click path
module button_event_decoder #(
  parameter int LONG_LIMIT = 25_000_000,
  parameter int GAP_LIMIT  = 7_500_000
) (
  input logic i_Clk,
  input logic i_Rst_L,
  button_event_decoder_if.slave bus
);
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
  localparam int MAX_LIMIT = (LONG_LIMIT > GAP_LIMIT) ? LONG_LIMIT : GAP_LIMIT;
`else
  localparam int MAX_LIMIT = LONG_LIMIT + 0 * GAP_LIMIT;
`endif
  localparam int W = $clog2(MAX_LIMIT);
  localparam logic [W-1:0] LAST_LONG = W'(LONG_LIMIT - 1);
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
  localparam logic [W-1:0] LAST_GAP = W'(GAP_LIMIT - 1);
`endif
  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
    ,
    WAIT_GAP,
    SECOND_PRESSED
`endif
  } state_t;
  state_t r_State, w_Next;
  logic [W-1:0] r_Count;
  logic r_Prev, w_Rise, w_Fall, w_Inc, w_Short, w_Long;
  logic r_Press, r_Release, r_Short, r_Long;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
  logic w_Double, r_Double;
`endif
  assign w_Rise = bus.i_Debounced & ~r_Prev;
  assign w_Fall = ~bus.i_Debounced & r_Prev;
  // next state and one-cycle event decisions; release is checked before the limit
  always_comb begin
    w_Next  = r_State;
    w_Inc   = 1'b0;
    w_Short = 1'b0;
    w_Long  = 1'b0;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
    w_Double = 1'b0;
`endif
    case (r_State)
      IDLE: w_Next = w_Rise ? PRESSED : IDLE;
      PRESSED:
        if (w_Fall) begin
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
          w_Next = WAIT_GAP;
`else
          w_Next  = IDLE;
          w_Short = 1'b1;
`endif
        end else if (r_Count == LAST_LONG) begin
          w_Long = 1'b1;
          w_Next = LONG_HELD;
        end else w_Inc = 1'b1;
      LONG_HELD: w_Next = w_Fall ? IDLE : LONG_HELD;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
      WAIT_GAP:
        if (r_Count == LAST_GAP) begin
          w_Short = 1'b1;
          w_Next  = w_Rise ? PRESSED : IDLE;
        end else if (w_Rise) w_Next = SECOND_PRESSED;
        else w_Inc = 1'b1;
      SECOND_PRESSED:
        if (w_Fall) begin
          w_Double = 1'b1;
          w_Next   = IDLE;
        end else if (r_Count == LAST_LONG) begin
          w_Long = 1'b1;
          w_Next = LONG_HELD;
        end else w_Inc = 1'b1;
`endif
      default: w_Next = IDLE;
    endcase
  end
  // state, saturating-free counter cleared on every state change, registered pulses
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State   <= IDLE;
      r_Count   <= '0;
      r_Prev    <= 1'b0;
      r_Press   <= 1'b0;
      r_Release <= 1'b0;
      r_Short   <= 1'b0;
      r_Long    <= 1'b0;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
      r_Double  <= 1'b0;
`endif
    end else begin
      r_State   <= w_Next;
      r_Count   <= (w_Next != r_State) ? '0 : w_Inc ? r_Count + 1'b1 : r_Count;
      r_Prev    <= bus.i_Debounced;
      r_Press   <= w_Rise;
      r_Release <= w_Fall;
      r_Short   <= w_Short;
      r_Long    <= w_Long;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
      r_Double  <= w_Double;
`endif
    end
  end
  assign bus.o_Press       = r_Press;
  assign bus.o_Release     = r_Release;
  assign bus.o_Short_Click = r_Short;
  assign bus.o_Long_Press  = r_Long;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
  assign bus.o_Double_Click = r_Double;
`else
  assign bus.o_Double_Click = 1'b0;
`endif
endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: scoreboard bench for button_event_decoder with LONG_LIMIT=8, GAP_LIMIT=5
module tb_button_event_decoder;
  localparam logic [4:0] P = 5'b00001, R = 5'b00010, S = 5'b00100, D = 5'b01000, L = 5'b10000;
  typedef struct {int cyc; logic [4:0] ev;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  exp_t q[$];
  logic [4:0] obs;
  button_event_decoder_if bus();
  button_event_decoder #(.LONG_LIMIT(8), .GAP_LIMIT(5)) dut (
    .i_Clk(clk),
    .i_Rst_L(rst_n),
    .bus(bus)
  );
  assign obs = {bus.o_Long_Press, bus.o_Double_Click, bus.o_Short_Click, bus.o_Release, bus.o_Press};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // pop expected events as the DUT produces them; flag missing and unexpected pulses
  always @(negedge clk) begin
    exp_t t;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_event cyc=%0d got=none expected=%b", q[0].cyc, q[0].ev);
      void'(q.pop_front());
    end
    if (obs !== 5'b0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d got=%b expected=none", cyc, obs);
      end else begin
        t = q.pop_front();
        if (t.cyc !== cyc || t.ev !== obs) begin
          errors++;
          $display("FAIL event cyc=%0d got=%b expected=%b at cyc=%0d", cyc, obs, t.ev, t.cyc);
        end
      end
    end
  end
  task automatic expect_ev(input int c, input logic [4:0] m);
    exp_t t;
    if (q.size() > 0 && q[$].cyc == c) begin
      t = q.pop_back();
      t.ev |= m;
      q.push_back(t);
    end else begin
      t.cyc = c;
      t.ev = m;
      q.push_back(t);
    end
  endtask
  task automatic drive(input logic v, input int n);
    bus.i_Debounced = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic check_drained(input string name);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s pending=%0d expected=0 next_cyc=%0d", name, q.size(), q[0].cyc);
    end
    q.delete();
  endtask
  task automatic test_reset();
    bus.i_Debounced = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b expected=00000", obs);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== 5'b0) begin
      errors++;
      $display("FAIL reset_hold got=%b expected=00000", obs);
    end
    rst_n = 1'b1;
    drive(1'b0, 6);
    check_drained("reset_idle");
  endtask
  task automatic test_single_click();
    int e = cyc + 1;
    expect_ev(e, P);
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
    expect_ev(e + 3, R);
    expect_ev(e + 8, S);
`else
    expect_ev(e + 3, R | S);
`endif
    drive(1'b1, 3);
    drive(1'b0, 12);
    check_drained("single_click");
  endtask
  task automatic test_double_click();
    int e = cyc + 1;
    expect_ev(e, P);
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
    expect_ev(e + 3, R);
    expect_ev(e + 5, P);
    expect_ev(e + 8, R | D);
`else
    expect_ev(e + 3, R | S);
    expect_ev(e + 5, P);
    expect_ev(e + 8, R | S);
`endif
    drive(1'b1, 3);
    drive(1'b0, 2);
    drive(1'b1, 3);
    drive(1'b0, 12);
    check_drained("double_click");
  endtask
  task automatic test_long_press();
    int e = cyc + 1;
    expect_ev(e, P);
    expect_ev(e + 8, L);
    expect_ev(e + 20, R);
    drive(1'b1, 20);
    drive(1'b0, 12);
    check_drained("long_press");
  endtask
  task automatic test_gap_boundary();
    int e = cyc + 1;
    expect_ev(e, P);
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
    expect_ev(e + 3, R);
    expect_ev(e + 8, S | P);
    expect_ev(e + 11, R);
    expect_ev(e + 16, S);
`else
    expect_ev(e + 3, R | S);
    expect_ev(e + 8, P);
    expect_ev(e + 11, R | S);
`endif
    drive(1'b1, 3);
    drive(1'b0, 5);
    drive(1'b1, 3);
    drive(1'b0, 12);
    check_drained("gap_boundary");
  endtask
  task automatic test_release_vs_limit();
    int e = cyc + 1;
    expect_ev(e, P);
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
    expect_ev(e + 8, R);
`else
    expect_ev(e + 8, R | S);
`endif
    expect_ev(e + 10, P);
    expect_ev(e + 18, L);
    expect_ev(e + 20, R);
    drive(1'b1, 8);
    drive(1'b0, 2);
    drive(1'b1, 10);
    drive(1'b0, 12);
    check_drained("release_vs_limit");
  endtask
  task automatic test_reset_mid();
    int e = cyc + 1;
    logic [4:0] want;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
    want = R;
`else
    want = R | S;
`endif
    expect_ev(e, P);
    drive(1'b1, 3);
    bus.i_Debounced = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL pre_reset_pulse got=%b expected=%b", obs, want);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 5'b0) begin
      errors++;
      $display("FAIL async_reset_outputs got=%b expected=00000", obs);
    end
    @(negedge clk);
    bus.i_Debounced = 1'b1;
    @(negedge clk);
    e = cyc + 1;
    expect_ev(e, P);
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
    expect_ev(e + 3, R);
    expect_ev(e + 8, S);
`else
    expect_ev(e + 3, R | S);
`endif
    rst_n = 1'b1;
    drive(1'b1, 3);
    drive(1'b0, 12);
    check_drained("reset_mid");
  endtask
  initial begin
    bus.i_Debounced = 1'b0;
    test_reset();
    test_single_click();
    test_double_click();
    test_long_press();
    test_gap_boundary();
    test_release_vs_limit();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
